// File: rtl/bsg_tag_packet_tx.sv
// Serial bsg_tag transmitter: takes one packet per valid/ready handshake and
// shifts it LSB-first onto the tag line, followed by a forced idle gap.
module bsg_tag_packet_tx #(
  parameter int els_p               = 1024,
  parameter int max_payload_width_p = 12,
  parameter int gap_p               = 2,
  localparam int lg_els   = $clog2(els_p),
  localparam int lg_width = $clog2(max_payload_width_p + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  output logic                           ready_and_o,
  input  logic [lg_els-1:0]              node_id_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width-1:0]            len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           tag_data_o,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [2:0]                     state_o
);

  localparam int max_a_lp   = (lg_els > max_payload_width_p) ? lg_els : max_payload_width_p;
  localparam int cnt_max_lp = (max_a_lp > gap_p) ? max_a_lp : gap_p;
  localparam int cnt_w      = $clog2(cnt_max_lp + 1);

  typedef enum logic [2:0] {
    s_idle, s_start, s_id, s_dnr, s_len, s_pay, s_gap
  } state_e;

  state_e                         state;
  logic [cnt_w-1:0]               cnt;
  logic [lg_els-1:0]              id_r;
  logic                           dnr_r;
  logic [lg_width-1:0]            len_r;
  logic [lg_width-1:0]            len_sh;
  logic [max_payload_width_p-1:0] pay_r;
  logic                           tag_data;
  logic                           err;
  logic                           accept;
  logic                           legal;

  // Handshake: a packet transfers on a rising edge where v_i & ready_and_o.
  // Ready is also raised in the final gap cycle so that a held v_i starts the
  // next packet right after exactly gap_p zero cycles, with no extra bubble.
  assign ready_and_o = (state == s_idle) || ((state == s_gap) && (cnt == '0));
  assign accept      = v_i && ready_and_o;
  assign legal       = (len_i != '0) && (len_i <= lg_width'(max_payload_width_p));
  assign busy_o      = (state != s_idle);
  assign tag_data_o  = tag_data;
  assign err_o       = err;
  assign state_o     = state;

  // tag_data holds the bit of the field named by state during this cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= s_idle;
      cnt      <= '0;
      id_r     <= '0;
      dnr_r    <= 1'b0;
      len_r    <= '0;
      len_sh   <= '0;
      pay_r    <= '0;
      tag_data <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        if (legal) begin
          state    <= s_start;
          tag_data <= 1'b1;
          id_r     <= node_id_i;
          dnr_r    <= data_not_reset_i;
          len_r    <= len_i;
          pay_r    <= payload_i;
        end else begin
          state    <= s_idle;
          tag_data <= 1'b0;
          err      <= 1'b1;
        end
      end else begin
        case (state)
          s_start: begin
            tag_data <= id_r[0];
            id_r     <= id_r >> 1;
            cnt      <= cnt_w'(lg_els - 1);
            state    <= s_id;
          end
          s_id: begin
            if (cnt == '0) begin
              tag_data <= dnr_r;
              state    <= s_dnr;
            end else begin
              tag_data <= id_r[0];
              id_r     <= id_r >> 1;
              cnt      <= cnt - cnt_w'(1);
            end
          end
          s_dnr: begin
            tag_data <= len_r[0];
            len_sh   <= len_r >> 1;
            cnt      <= cnt_w'(lg_width - 1);
            state    <= s_len;
          end
          s_len: begin
            if (cnt == '0) begin
              tag_data <= pay_r[0];
              pay_r    <= pay_r >> 1;
              cnt      <= cnt_w'(len_r) - cnt_w'(1);
              state    <= s_pay;
            end else begin
              tag_data <= len_sh[0];
              len_sh   <= len_sh >> 1;
              cnt      <= cnt - cnt_w'(1);
            end
          end
          s_pay: begin
            if (cnt == '0) begin
              tag_data <= 1'b0;
              cnt      <= cnt_w'(gap_p - 1);
              state    <= s_gap;
            end else begin
              tag_data <= pay_r[0];
              pay_r    <= pay_r >> 1;
              cnt      <= cnt - cnt_w'(1);
            end
          end
          s_gap: begin
            tag_data <= 1'b0;
            if (cnt == '0) state <= s_idle;
            else           cnt   <= cnt - cnt_w'(1);
          end
          default: begin
            tag_data <= 1'b0;
            state    <= s_idle;
          end
        endcase
      end
    end
  end

endmodule
